// File: rtl/adder_rr_sched.sv
// -----------------------------------------------------------------------------
// adder_rr_sched
//
// Round-robin front end for a shared, externally instantiated 2-stage
// pipelined 8-bit adder. Each cycle, at most one of NREQ requesters is granted.
// Its operands are steered onto the adder ports. A valid+ID tag travels
// alongside the adder pipeline, so the result that emerges LAT edges later is
// labelled with the requester that issued it. The adder has no valid or reset
// of its own. Its output is used only when the tag says it is valid.
//
// Parameters
//   NREQ  number of requesters (2..8)
//   IDW   requester ID width, equal to ceil(log2(NREQ))
//   LAT   adder latency in clock edges; must equal the adder pipeline depth
//
// Ports
//   clk, rst_n          clock (rising edge) / asynchronous active-low reset
//   en                  grant enable; in-flight tags drain while low
//   req_valid[NREQ]     per-requester request
//   req_a/req_b[8*NREQ] operands; requester i occupies bits [8i+7:8i]
//   req_cin[NREQ]       per-requester carry-in
//   req_ready[NREQ]     one-hot grant (accept = req_valid & req_ready)
//   add_a/add_b/add_cin operands driven to the adder (zero when idle)
//   add_sum/add_cout    adder result, LAT edges after the operands
//   rsp_valid/rsp_id    result valid and owning requester
//   rsp_sum/rsp_cout    adder result passed straight through
//   busy                at least one tag in flight
//   issue_cnt           accepted-request count, wraps 0xFFFF -> 0
// -----------------------------------------------------------------------------
module adder_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        add_a,
  output logic [7:0]        add_b,
  output logic              add_cin,
  input  logic [7:0]        add_sum,
  input  logic              add_cout,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_sum,
  output logic              rsp_cout,
  output logic              busy,
  output logic [15:0]       issue_cnt
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IDW-1:0] r_ptr;              // highest-priority requester index
  logic [LAT-1:0] r_tag_vld;          // per-stage valid, stage 0 is youngest
  logic [IDW-1:0] r_tag_id [LAT];     // per-stage requester ID
  logic [15:0]    r_issue_cnt;

  // ---------------------------------------------------------------------------
  // Arbitration: first requesting index at or after r_ptr, modulo NREQ
  // ---------------------------------------------------------------------------
  logic           w_found;
  logic [IDW-1:0] w_gnt_id;
  logic           w_accept;
  logic [IDW-1:0] w_ptr_nxt;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_found  = 1'b0;
    w_gnt_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[(int'(r_ptr) + k) % NREQ]) begin
        w_found  = 1'b1;
        w_gnt_id = IDW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  // A grant is offered only when enabled and out of reset. Because the grant
  // index always points at a requesting client, an offered grant is an accept.
  assign w_accept  = w_found & en & rst_n;
  assign w_ptr_nxt = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + IDW'(1);

  // ---------------------------------------------------------------------------
  // Grant and adder operand steering. Idle operands are forced to zero, so the
  // idle adder output is deterministic.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    if (w_accept) begin
      req_ready[w_gnt_id] = 1'b1;
      add_a               = req_a[8*int'(w_gnt_id) +: 8];
      add_b               = req_b[8*int'(w_gnt_id) +: 8];
      add_cin             = req_cin[w_gnt_id];
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer, issue counter and tag pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_tag_vld   <= '0;
      r_issue_cnt <= '0;
      // NOTE: the tag ID array is only LAT entries deep and rsp_id must read 0
      // in reset, so it is reset with the rest of the state rather than being
      // treated as an unreset memory.
      for (int k = 0; k < LAT; k++) begin
        r_tag_id[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every stage samples the
      // pre-edge value of the previous stage and the shift is order-independent.
      if (w_accept) begin
        r_ptr       <= w_ptr_nxt;
        r_issue_cnt <= r_issue_cnt + 16'd1;
      end
      r_tag_vld[0] <= w_accept;
      r_tag_id[0]  <= w_accept ? w_gnt_id : '0;
      for (int k = 1; k < LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response: the tag's last stage lines up with the adder's output register
  // ---------------------------------------------------------------------------
  assign rsp_valid = r_tag_vld[LAT-1];
  assign rsp_id    = r_tag_id[LAT-1];
  assign rsp_sum   = add_sum;
  assign rsp_cout  = add_cout;
  assign busy      = |r_tag_vld;
  assign issue_cnt = r_issue_cnt;

endmodule

// File: tb/tb_adder_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_adder_rr_sched
//
// Self-checking bench for adder_rr_sched with a behavioural 2-stage adder
// attached to the add_* ports. It has directed vectors, hand-written sequences,
// a randomized run against a queue-based reference model, and an issue
// counter wrap.
// -----------------------------------------------------------------------------
module tb_adder_rr_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 2;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [NREQ-1:0]  req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]  req_cin;
  logic [NREQ-1:0]  req_ready;
  logic [7:0]       add_a;
  logic [7:0]       add_b;
  logic             add_cin;
  logic [7:0]       add_sum;
  logic             add_cout;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic [7:0]       rsp_sum;
  logic             rsp_cout;
  logic             busy;
  logic [15:0]      issue_cnt;

  adder_rr_sched #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_ready (req_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy),
    .issue_cnt (issue_cnt)
  );

  // Shared adder: two register stages, no reset, no valid.
  logic [8:0] adder_s1;
  logic [8:0] adder_s2;
  always @(posedge clk) begin
    adder_s1 <= {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
    adder_s2 <= adder_s1;
  end
  assign add_sum  = adder_s2[7:0];
  assign add_cout = adder_s2[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check()
  // ---------------------------------------------------------------------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: rotating priority pointer and a queue of timestamped
  // results, each due LAT-1 edges after its accept edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    int id;
    int res;
    int due;
  } rsp_t;

  rsp_t exp_q[$];
  int   mdl_ptr = 0;
  int   mdl_cnt = 0;
  int   edge_n  = 0;

  task automatic model_cycle(output int g);
    logic [3:0] e_rdy;
    int         ea, eb, ec, res;
    rsp_t       r;
    #1;
    g = -1;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(mdl_ptr + k) % NREQ]) g = (mdl_ptr + k) % NREQ;
      end
    end
    e_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    ea = 0; eb = 0; ec = 0;
    if (g >= 0) begin
      ea = int'(req_a[8*g +: 8]);
      eb = int'(req_b[8*g +: 8]);
      ec = int'(req_cin[g]);
    end
    res = ea + eb + ec;
    check("rnd req_ready", req_ready, e_rdy);
    check("rnd add_a", add_a, ea);
    check("rnd add_b", add_b, eb);
    check("rnd add_cin", add_cin, ec);
    check("rnd busy", busy, exp_q.size() != 0);
    check("rnd issue_cnt", issue_cnt, mdl_cnt);
    if (exp_q.size() != 0 && exp_q[0].due == edge_n) begin
      r = exp_q.pop_front();
      check("rnd rsp_valid", rsp_valid, 1);
      check("rnd rsp_id", rsp_id, r.id);
      check("rnd rsp_result", {rsp_cout, rsp_sum}, r.res);
    end else begin
      check("rnd rsp_valid", rsp_valid, 0);
    end
    @(posedge clk);
    edge_n++;
    if (g >= 0) begin
      exp_q.push_back('{g, res, edge_n + LAT - 1});
      mdl_ptr = (g + 1) % NREQ;
      mdl_cnt = (mdl_cnt + 1) % 65536;
    end
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Hand-written cycle: check comb + registered outputs, then advance one edge
  // ---------------------------------------------------------------------------
  task automatic hand_cycle(input string tag, input logic [3:0] e_rdy, input logic e_rv,
                            input logic [1:0] e_id, input logic [8:0] e_res, input logic e_busy);
    #1;
    check({tag, " req_ready"}, req_ready, e_rdy);
    if (e_rdy == 4'b0000) begin
      check({tag, " idle_operands"}, {add_a, add_b, add_cin}, 0);
    end
    check({tag, " rsp_valid"}, rsp_valid, e_rv);
    if (e_rv) begin
      check({tag, " rsp_id"}, rsp_id, e_id);
      check({tag, " rsp_result"}, {rsp_cout, rsp_sum}, e_res);
    end
    check({tag, " busy"}, busy, e_busy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    en        = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    mdl_ptr = 0;
    mdl_cnt = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors, applied back to back starting from reset (priority 0).
  // Each record's response is expected two records later.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0]  valid;
    logic        en;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  cin;
    logic [3:0]  rdy;
    logic [1:0]  id;
    logic [8:0]  res;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic       rv, bz;
    logic [3:0] e_rdy;
    logic [1:0] eid;
    logic [8:0] eres;
    int         last_g;

    tbl[0]  = '{4'b0100, 1'b1, 32'h003C0000, 32'h00150000, 4'b0100, 4'b0100, 2'd2, 9'h052};
    tbl[1]  = '{4'b1000, 1'b1, 32'hFF000000, 32'h01000000, 4'b0000, 4'b1000, 2'd3, 9'h100};
    tbl[2]  = '{4'b0001, 1'b1, 32'h000000FF, 32'h000000FF, 4'b0001, 4'b0001, 2'd0, 9'h1FF};
    tbl[3]  = '{4'b0010, 1'b1, 32'hAA550077, 32'h12340056, 4'b1101, 4'b0010, 2'd1, 9'h000};
    tbl[4]  = '{4'b1010, 1'b0, 32'h30201000, 32'h01010101, 4'b0000, 4'b0000, 2'd0, 9'h000};
    tbl[5]  = '{4'b1111, 1'b1, 32'h30201000, 32'h01010101, 4'b0000, 4'b0100, 2'd2, 9'h021};
    tbl[6]  = '{4'b1011, 1'b1, 32'h30201000, 32'h01010101, 4'b0000, 4'b1000, 2'd3, 9'h031};
    tbl[7]  = '{4'b0110, 1'b1, 32'h30201000, 32'h01010101, 4'b0000, 4'b0010, 2'd1, 9'h011};
    tbl[8]  = '{4'b0011, 1'b1, 32'h30201000, 32'h01010101, 4'b0000, 4'b0001, 2'd0, 9'h001};
    tbl[9]  = '{4'b0000, 1'b1, 32'h00000000, 32'h00000000, 4'b0000, 4'b0000, 2'd0, 9'h000};
    tbl[10] = '{4'b0000, 1'b1, 32'h00000000, 32'h00000000, 4'b0000, 4'b0000, 2'd0, 9'h000};

    // ---- reset state: requests pending and enabled, but reset holds grants off
    rst_n     = 1'b0;
    en        = 1'b1;
    req_valid = 4'b1111;
    req_a     = 32'h11223344;
    req_b     = 32'h55667788;
    req_cin   = 4'b1111;
    #3;
    check("reset req_ready", req_ready, 0);
    check("reset operands", {add_a, add_b, add_cin}, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_id", rsp_id, 0);
    check("reset busy", busy, 0);
    check("reset issue_cnt", issue_cnt, 0);

    // ---- directed table
    do_reset();
    for (int i = 0; i < 11; i++) begin
      req_valid = tbl[i].valid;
      en        = tbl[i].en;
      req_a     = tbl[i].a;
      req_b     = tbl[i].b;
      req_cin   = tbl[i].cin;
      rv = 1'b0; eid = '0; eres = '0; bz = 1'b0;
      if (i >= 2) begin
        rv   = (tbl[i-2].rdy != 4'b0000);
        eid  = tbl[i-2].id;
        eres = tbl[i-2].res;
        bz   = rv;
      end
      if (i >= 1 && tbl[i-1].rdy != 4'b0000) bz = 1'b1;
      hand_cycle($sformatf("vec%0d", i), tbl[i].rdy, rv, eid, eres, bz);
    end
    check("vec issue_cnt", issue_cnt, 8);

    // ---- full contention: strict rotation 0,1,2,3,... with no bubbles
    do_reset();
    req_a = 32'h30201000; req_b = 32'h01010101; req_cin = 4'b0000;
    req_valid = 4'b1111; en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 8) req_valid = 4'b0000;
      e_rdy = (i < 8) ? 4'(1 << (i % 4)) : 4'b0000;
      rv    = (i >= 2 && i <= 9);
      eid   = rv ? 2'((i - 2) % 4) : 2'd0;
      eres  = rv ? 9'(16 * ((i - 2) % 4) + 1) : 9'd0;
      hand_cycle($sformatf("rot%0d", i), e_rdy, rv, eid, eres, (i >= 1 && i <= 9));
    end
    check("rot issue_cnt", issue_cnt, 8);

    // ---- enable gating, pointer hold and busy drain
    do_reset();
    req_a = 32'h30201000; req_b = 32'h01010101; req_cin = 4'b0000;
    req_valid = 4'b1010; en = 1'b0;
    for (int i = 0; i < 3; i++) hand_cycle("gate_off", 4'b0000, 0, 0, 0, 0);
    en = 1'b1;
    hand_cycle("gate_first", 4'b0010, 0, 0, 0, 0);
    req_valid = 4'b1000;
    hand_cycle("gate_second", 4'b1000, 0, 0, 0, 1);
    req_valid = 4'b1111;
    hand_cycle("gate_wrap", 4'b0001, 1, 2'd1, 9'h011, 1);
    req_valid = 4'b1110; en = 1'b0;
    hand_cycle("gate_hold", 4'b0000, 1, 2'd3, 9'h031, 1);
    hand_cycle("gate_drain", 4'b0000, 1, 2'd0, 9'h001, 1);
    hand_cycle("gate_idle", 4'b0000, 0, 0, 0, 0);
    en = 1'b1;
    hand_cycle("gate_ptr_held", 4'b0010, 0, 0, 0, 0);
    req_valid = 4'b0000;
    hand_cycle("gate_d1", 4'b0000, 0, 0, 0, 1);
    hand_cycle("gate_d2", 4'b0000, 1, 2'd1, 9'h011, 1);
    hand_cycle("gate_d3", 4'b0000, 0, 0, 0, 0);
    check("gate issue_cnt", issue_cnt, 4);

    // ---- reset mid-flight: in-flight tags discarded, pointer back to 0
    do_reset();
    req_a = 32'h30201000; req_b = 32'h01010101; req_cin = 4'b0000;
    req_valid = 4'b0001; en = 1'b1;
    hand_cycle("mid_t0", 4'b0001, 0, 0, 0, 0);
    req_valid = 4'b0010;
    hand_cycle("mid_t1", 4'b0010, 0, 0, 0, 1);
    rst_n = 1'b0;
    req_valid = 4'b1011;
    #1;
    check("mid reset req_ready", req_ready, 0);
    check("mid reset operands", {add_a, add_b, add_cin}, 0);
    check("mid reset rsp_valid", rsp_valid, 0);
    check("mid reset busy", busy, 0);
    check("mid reset issue_cnt", issue_cnt, 0);
    @(posedge clk);
    #1;
    check("mid reset rsp_valid hold", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hand_cycle("mid_regrant", 4'b0001, 0, 0, 0, 0);
    req_valid = 4'b0000;
    hand_cycle("mid_after1", 4'b0000, 0, 0, 0, 1);
    hand_cycle("mid_after2", 4'b0000, 1, 2'd0, 9'h001, 1);
    check("mid issue_cnt", issue_cnt, 1);

    // ---- randomized traffic against the reference model
    do_reset();
    last_g = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || last_g == i) begin
          req_valid[i]    = ($urandom_range(0, 99) < 55);
          req_a[8*i +: 8] = 8'($urandom);
          req_b[8*i +: 8] = 8'($urandom);
          req_cin[i]      = 1'($urandom);
        end
      end
      en = ($urandom_range(0, 99) < 80);
      model_cycle(last_g);
    end

    // ---- issue counter wrap with one requester granted back to back
    do_reset();
    req_a = 32'h30201000; req_b = 32'h01010101; req_cin = 4'b0000;
    req_valid = 4'b0001; en = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    check("wrap issue_cnt ffff", issue_cnt, 16'hFFFF);
    check("wrap back_to_back ready", req_ready, 4'b0001);
    check("wrap back_to_back rsp_valid", rsp_valid, 1);
    check("wrap back_to_back rsp_id", rsp_id, 0);
    check("wrap back_to_back busy", busy, 1);
    @(posedge clk);
    #1;
    check("wrap issue_cnt zero", issue_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adder_rr_sched.md
Name: adder_rr_sched

Overview:
- Round-robin scheduler that shares one 2-stage pipelined 8-bit adder among NREQ requesters.
- The adder has no valid or reset of its own. This block drives the adder's A/B/cin ports, grants at most one request per cycle, and carries a valid+requester-ID tag alongside the adder pipeline.
- Each result is returned with the ID of the requester that issued it.
- It sits between client blocks and the adder instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal ceil(log2(NREQ)).
- LAT, 2, adder latency in clock edges; must match the adder pipeline depth.

Ports:
- clk  in  1  single clock; all state on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  grant enable; when low, no new grants are made and in-flight tags still drain.
- req_valid  in  NREQ  per-requester request.
- req_a  in  8*NREQ  operand A; requester i occupies bits [8i+7:8i].
- req_b  in  8*NREQ  operand B, same packing as req_a.
- req_cin  in  NREQ  carry-in per requester.
- req_ready  out  NREQ  one-hot grant; a request is accepted at an edge where req_valid[i] and req_ready[i] are both high.
- add_a  out  8  operand A to the adder.
- add_b  out  8  operand B to the adder.
- add_cin  out  1  carry-in to the adder.
- add_sum  in  8  adder sum output.
- add_cout  in  1  adder carry output.
- rsp_valid  out  1  result valid this cycle.
- rsp_id  out  IDW  requester ID that owns the result.
- rsp_sum  out  8  result sum.
- rsp_cout  out  1  result carry.
- busy  out  1  at least one tag is in flight.
- issue_cnt  out  16  count of accepted requests; wraps at 65535 to 0.

Behaviour:
- Arbitration (combinational):
  - ptr (IDW bits) is the highest-priority index.
  - Grant goes to the first i with req_valid[i] high, scanning ptr, ptr+1, ... mod NREQ.
  - req_ready is one-hot at that index, or all-zero when en=0, no request is pending, or rst_n=0.
  - Requesters must hold req_valid and operands stable until accepted.
- Adder drive (combinational):
  - add_a, add_b and add_cin equal the granted requester's operands.
  - They are 0 when there is no grant, so the idle adder output is deterministic.
  - The adder samples these ports on the acceptance edge.
- Pointer update: on an accept by requester g, ptr <= (g+1) mod NREQ. With no accept, ptr is held.
- Tag pipeline:
  - LAT stages, each holding valid + id.
  - Stage 0 loads {accept, g} every edge; stage k loads stage k-1.
  - A bubble loads valid=0.
- Response:
  - rsp_valid = tag[LAT-1].valid and rsp_id = tag[LAT-1].id.
  - rsp_sum = add_sum and rsp_cout = add_cout, passed through unregistered.
  - Request accepted at edge T → rsp_valid high in the cycle after edge T+LAT-1, sampled by the consumer at edge T+LAT.
  - Latency is 2 edges at default. Throughput is 1 per cycle.
- No response backpressure: the adder cannot stall, so the consumer must accept every rsp_valid cycle.
- busy is the OR of all tag valids.
- issue_cnt increments by 1 on every accept.
- Reset (async, rst_n=0):
  - ptr=0, all tag valids=0, ids=0, issue_cnt=0.
  - Outputs: rsp_valid=0, rsp_id=0, busy=0, req_ready=0.
  - add_a=0, add_b=0, add_cin=0.
- Reset mid-operation:
  - In-flight tags are discarded, so no response is emitted for them.
  - Stale adder contents appear on add_sum but are masked by rsp_valid=0.
  - The first grant after release goes to requester 0 if it is requesting.
- Boundary conditions:
  - All requesters valid every cycle: grants rotate 0,1,2,3,0,...
  - Single requester valid continuously: it is granted every cycle (back-to-back).
  - en deasserting while requests are pending: no accept that cycle, ptr held, tags drain, and busy falls LAT cycles after the last accept.
  - Carry: the result is the 9-bit sum of A+B+cin, with cout as the MSB. 0xFF+0x01+0 → sum 0x00, cout 1. 0xFF+0xFF+1 → sum 0xFF, cout 1.

Test Plan:
- Single request: req 2 with A=0x3C, B=0x15, cin=1, accepted at edge T → rsp_valid at edge T+2 with id=2, sum=0x52, cout=0; issue_cnt=1; busy high for 2 cycles.
- Full contention: all 4 valid for 8 cycles, each requester i using A=0x10*i, B=0x01 → grants in order 0,1,2,3,0,1,2,3; responses in the same order 2 cycles later with sums 0x01,0x11,0x21,0x31; no bubbles.
- Carry corners: A=0xFF, B=0x01, cin=0 → sum 0x00, cout 1. A=0xFF, B=0xFF, cin=1 → sum 0xFF, cout 1. A=0, B=0, cin=0 → sum 0x00, cout 0.
- Gating: requests 1 and 3 pending, en low for 3 cycles → req_ready=0 and no rsp_valid; after en rises, requester 1 is granted first (ptr=0), then requester 3.
- Reset mid-flight: accepts at edges T and T+1, then rst_n pulsed low between T+1 and T+2 → no rsp_valid, busy=0, issue_cnt=0, ptr=0; the next grant goes to the lowest-index valid requester.
- Counter wrap: 65536 accepts → issue_cnt returns to 0; it is 0xFFFF after accept 65535.
